// File: rtl/inv_sub_bytes_seq.sv
// Sequential AES InvSubBytes: a 128-bit state is pushed through LANES
// time-shared InvSbox instances, LANES bytes per clock, with valid/ready handshakes.

module inv_sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] t;
  logic [7:0] sq;
  logic [7:0] r;

  // Inverse affine map, then multiplicative inverse as t^254 (maps 0 to 0).
  always_comb begin
    t  = {a_i[6:0], a_i[7]} ^ {a_i[4:0], a_i[7:5]} ^ {a_i[1:0], a_i[7:2]} ^ 8'h05;
    sq = t;
    r  = 8'h01;
    for (int unsigned i = 0; i < 7; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    y_o = r;
  end

endmodule

module inv_sub_bytes_seq #(
  parameter int unsigned LANES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int unsigned GROUPS = 16 / LANES;
  localparam int unsigned CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(GROUPS - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [127:0]  work_q, work_d;

  logic [7:0] lane_in  [LANES];
  logic [7:0] lane_out [LANES];
  logic [6:0] lane_lsb [LANES];

  // Byte k of the state lives at bits [127-8k -: 8], i.e. LSB 8*(15-k).
  always_comb begin
    for (int unsigned g = 0; g < LANES; g++) begin
      lane_lsb[g] = 7'(8 * (15 - (32'(cnt_q) * LANES + g)));
      lane_in[g]  = work_q[lane_lsb[g] +: 8];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    inv_sbox u_sbox (
      .a_i (lane_in[g]),
      .y_o (lane_out[g])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = in_data;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int unsigned g = 0; g < LANES; g++) begin
          work_d[lane_lsb[g] +: 8] = lane_out[g];
        end
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = work_q;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Randomized and directed bench for inv_sub_bytes_seq at LANES = 1, 4 and 16,
// checked against a table-based model built from the forward S-box definition.

module tb_inv_sub_bytes_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic [127:0] in_data;
  logic         ir  [3];
  logic         ov  [3];
  logic         bsy [3];
  logic [127:0] od  [3];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  localparam logic [127:0] VEC    = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] VECOUT = 128'h52096AD53036A538BF40A39E81F3D7FB;
  localparam int LAT [3] = '{16, 4, 1};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  inv_sub_bytes_seq #(.LANES(1)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .busy(bsy[0]));
  inv_sub_bytes_seq #(.LANES(4)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .busy(bsy[1]));
  inv_sub_bytes_seq #(.LANES(16)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .in_data(in_data),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]), .busy(bsy[2]));

  logic [7:0] inv_tab [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11B << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  task automatic build_table();
    logic [7:0] x, y, s;
    for (int i = 0; i < 256; i++) begin
      x = 8'(i);
      y = 8'h00;
      for (int j = 1; j < 256; j++) if (gmul(x, 8'(j)) == 8'h01) y = 8'(j);
      s = y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
      inv_tab[s] = x;
    end
  endtask

  function automatic logic [127:0] invmap(input logic [127:0] d);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[8*(15-k) +: 8] = inv_tab[d[8*(15-k) +: 8]];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: each DUT is idle, or counting down to a held result.
  bit           m_idle [3] = '{1, 1, 1};
  bit           m_zero [3] = '{1, 1, 1};
  int           m_left [3] = '{0, 0, 0};
  logic [127:0] m_res  [3];

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      logic e_idle, e_valid;
      e_idle  = rst | m_idle[d];
      e_valid = !rst && !m_idle[d] && (m_left[d] == 0);
      chk($sformatf("in_ready%0d", d), 128'(ir[d]), 128'(e_idle));
      chk($sformatf("out_valid%0d", d), 128'(ov[d]), 128'(e_valid));
      chk($sformatf("busy%0d", d), 128'(bsy[d]), 128'(!e_idle));
      if (rst || m_zero[d]) chk($sformatf("out_data_zero%0d", d), od[d], '0);
      else if (e_valid) chk($sformatf("out_data%0d", d), od[d], m_res[d]);
      if (rst) begin
        m_idle[d] = 1'b1;
        m_zero[d] = 1'b1;
      end else if (m_idle[d]) begin
        if (in_valid) begin
          m_idle[d] = 1'b0;
          m_zero[d] = 1'b0;
          m_left[d] = LAT[d];
          m_res[d]  = invmap(in_data);
        end
      end else if (m_left[d] > 0) begin
        m_left[d]--;
      end else if (out_ready) begin
        m_idle[d] = 1'b1;
      end
    end
  end

  initial begin
    int acc, n, lat0, nacc, nres;
    int lat [3];
    int rt [2];
    logic [127:0] rd [2];

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    build_table();
    chk("tab_63", 128'(inv_tab[8'h63]), 128'h00);
    chk("tab_7c", 128'(inv_tab[8'h7C]), 128'h01);
    chk("tab_00", 128'(inv_tab[8'h00]), 128'h52);
    chk("tab_ff", 128'(inv_tab[8'hFF]), 128'h7D);
    chk("model_vec", invmap(VEC), VECOUT);
    @(posedge clk); #1;
    chk("rst_in_ready", 128'(ir[0]), 128'h1);
    chk("rst_out_data", od[0], '0);
    @(posedge clk); #1 rst = 1'b0;

    // All-0x63 state: latency 16 and 17 busy cycles
    @(posedge clk); #1 out_ready = 1'b1; in_valid = 1'b1; in_data = {16{8'h63}};
    @(posedge clk); #1 in_valid = 1'b0; acc = cyc;
    n = 0; lat0 = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ov[0] && lat0 < 0) begin
        lat0 = cyc - acc;
        chk("x63_data", od[0], '0);
      end
      if (bsy[0]) n++;
      else break;
    end
    chk("x63_latency", 128'(lat0), 128'd16);
    chk("x63_busy_cycles", 128'(n), 128'd17);

    // Byte ordering, latency per LANES, then backpressure
    @(posedge clk); #1 out_ready = 1'b0; in_valid = 1'b1; in_data = VEC;
    @(posedge clk); #1 in_valid = 1'b0; acc = cyc;
    lat = '{-1, -1, -1};
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) if (ov[d] && lat[d] < 0) lat[d] = cyc - acc;
      if (ov[0]) break;
    end
    chk("vec_wait", 128'(ov[0]), 128'h1);
    chk("vec_lat1", 128'(lat[0]), 128'd16);
    chk("vec_lat4", 128'(lat[1]), 128'd4);
    chk("vec_lat16", 128'(lat[2]), 128'd1);
    for (int d = 0; d < 3; d++) chk($sformatf("vec_data%0d", d), od[d], VECOUT);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = (i == 4);
      in_data  = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      chk("bp_valid", 128'(ov[0]), 128'h1);
      chk("bp_data", od[0], VECOUT);
      chk("bp_in_ready", 128'(ir[0]), 128'h0);
    end
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;
    chk("bp_release_ready", 128'(ir[0]), 128'h1);
    chk("bp_release_valid", 128'(ov[0]), 128'h0);

    // Reset at cnt = 7, then an all-0x7C state
    @(posedge clk); #1 out_ready = 1'b1; in_valid = 1'b1;
    in_data = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 128'(ir[0]), 128'h1);
    chk("mid_rst_out_valid", 128'(ov[0]), 128'h0);
    chk("mid_rst_busy", 128'(bsy[0]), 128'h0);
    chk("mid_rst_out_data", od[0], '0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1 in_valid = 1'b1; in_data = {16{8'h7C}};
    @(posedge clk); #1 in_valid = 1'b0;
    for (int i = 0; i < 30 && !ov[0]; i++) @(negedge clk);
    chk("x7c_wait", 128'(ov[0]), 128'h1);
    chk("x7c_data", od[0], {16{8'h01}});

    // Back-to-back throughput
    @(posedge clk); #1 in_valid = 1'b1; out_ready = 1'b1; in_data = '0;
    nacc = 0; nres = 0;
    for (int i = 0; i < 80 && nres < 2; i++) begin
      @(negedge clk);
      if (ov[0] && out_ready) begin
        rt[nres] = cyc;
        rd[nres] = od[0];
        nres++;
      end
      if (ir[0] && in_valid) nacc++;
      @(posedge clk); #1;
      if (nacc >= 1) in_data = '1;
    end
    in_valid = 1'b0;
    chk("b2b_count", 128'(nres), 128'd2);
    if (nres == 2) begin
      chk("b2b_first", rd[0], {16{8'h52}});
      chk("b2b_second", rd[1], {16{8'h7D}});
      chk("b2b_spacing", 128'(rt[1] - rt[0]), 128'd18);
    end

    // Randomized traffic with occasional reset pulses
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) == 0);
      in_data   = in_valid ? {$urandom, $urandom, $urandom, $urandom} : 'x;
      out_ready = ($urandom_range(0, 2) != 0);
      rst       = ($urandom_range(0, 149) == 0);
    end
    @(posedge clk); #1 rst = 1'b0; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
